// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_pkg
// Description : Shared types and constants for the Mandelbrot frame
//               sequencer: FSM state encoding, configuration record and the
//               field widths used by the pixel core.
// Revision    : 1.0 - initial release
// ============================================================================
package mandelbrot_pkg;

   localparam int CTR_SELECT_W = 3;
   localparam int SCALING_W    = 7;
   localparam int NIBBLE_W     = 4;
   localparam int CFG_CTRWIDTH = 7;
   localparam int CFG_BITWIDTH = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_PUSH  = 3'd4
   } frame_state_t;

   typedef struct packed {
      logic [CFG_CTRWIDTH-1:0] max_ctr;
      logic [CTR_SELECT_W-1:0] ctr_select;
      logic [SCALING_W-1:0]    scaling;
      logic [CFG_BITWIDTH-1:0] cr_offset;
      logic [CFG_BITWIDTH-1:0] ci_offset;
   } mandelbrot_cfg_t;

   // Power-up configuration: full iteration budget, no zoom, no pan
   localparam mandelbrot_cfg_t CFG_RESET = '{
      max_ctr:    '1,
      ctr_select: '0,
      scaling:    '0,
      cr_offset:  '0,
      ci_offset:  '0
   };

endpackage
`default_nettype wire

// File: rtl/mandelbrot_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_pixel_fifo
// Description : Synchronous FIFO holding {last, nibble} pixel entries with
//               fill count, full and empty flags. Push and pop in the same
//               cycle is allowed at any fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_pixel_fifo
   import mandelbrot_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = NIBBLE_W + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // accepted only when paired with a pop
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Pointers and fill count; pointers wrap naturally since DEPTH is 2^n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

`ifndef SYNTHESIS
   // A write into a full FIFO without a paired pop would drop a pixel
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && full && !do_pop))
            else $error("pixel fifo written while full");
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/mandelbrot_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_frame_ctrl
// Description : Frame sequencer for the Mandelbrot pixel core. Issues one
//               run pulse per pixel, buffers each result nibble in a pixel
//               FIFO with back-pressure, and swaps shadowed zoom/pan
//               configuration in only at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_frame_ctrl
   import mandelbrot_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int BITWIDTH   = CFG_BITWIDTH,
   parameter int CTRWIDTH   = CFG_CTRWIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    single_frame,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CTRWIDTH-1:0]     cfg_max_ctr,
   input  logic [CTR_SELECT_W-1:0] cfg_ctr_select,
   input  logic [SCALING_W-1:0]    cfg_scaling,
   input  logic [BITWIDTH-1:0]     cfg_cr_offset,
   input  logic [BITWIDTH-1:0]     cfg_ci_offset,
   output logic                    core_run,
   input  logic                    core_running,
   input  logic                    core_finished,
   input  logic [NIBBLE_W-1:0]     core_ctr_out,
   output logic [CTRWIDTH-1:0]     core_max_ctr,
   output logic [CTR_SELECT_W-1:0] core_ctr_select,
   output logic [SCALING_W-1:0]    core_scaling,
   output logic [BITWIDTH-1:0]     core_cr_offset,
   output logic [BITWIDTH-1:0]     core_ci_offset,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [NIBBLE_W-1:0]     pix_data,
   output logic                    pix_last,
   output logic                    frame_done,
   output logic [15:0]             frame_count,
   output logic                    busy
);

   localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] ROOM_CNT = CNT_W'(FIFO_DEPTH - 1);

   frame_state_t          state;
   frame_state_t          next_state;

   logic                  seen_running;
   logic [NIBBLE_W-1:0]   lat_nibble;
   logic                  lat_last;
   logic                  wait_done;
   logic                  room_after_push;

   mandelbrot_cfg_t       incoming_cfg;
   mandelbrot_cfg_t       pending_cfg;
   mandelbrot_cfg_t       active_cfg;
   logic                  pending_valid;
   logic                  apply_done;
   logic                  cfg_accept;
   logic                  cfg_copy;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic [NIBBLE_W:0]     fifo_dout;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Pixel result is complete once the core has been seen running and drops
   assign wait_done = (state == ST_WAIT) && seen_running && !core_running;

   // Space must remain after the current push for another pixel to be issued
   assign room_after_push = (fifo_count < ROOM_CNT) || fifo_pop;

   assign incoming_cfg = '{
      max_ctr:    cfg_max_ctr,
      ctr_select: cfg_ctr_select,
      scaling:    cfg_scaling,
      cr_offset:  cfg_cr_offset,
      ci_offset:  cfg_ci_offset
   };

   // Copy only on the first APPLY cycle so a config accepted while APPLY
   // lingers on a full FIFO waits for the next boundary
   assign cfg_ready  = !pending_valid;
   assign cfg_accept = cfg_valid && cfg_ready;
   assign cfg_copy   = (state == ST_APPLY) && !apply_done && pending_valid;

   assign core_max_ctr    = active_cfg.max_ctr;
   assign core_ctr_select = active_cfg.ctr_select;
   assign core_scaling    = active_cfg.scaling;
   assign core_cr_offset  = active_cfg.cr_offset;
   assign core_ci_offset  = active_cfg.ci_offset;

   assign pix_valid = !fifo_empty;
   assign pix_data  = fifo_empty ? '0 : fifo_dout[NIBBLE_W-1:0];
   assign pix_last  = !fifo_empty && fifo_dout[NIBBLE_W];
   assign fifo_pop  = pix_valid && pix_ready;
   assign busy      = (state != ST_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // FSM next-state and per-state strobes
   always_comb begin
      next_state = state;
      fifo_push  = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               if (core_finished)   next_state = ST_APPLY;
               else if (!fifo_full) next_state = ST_ISSUE;
            end
         end
         ST_APPLY: begin
            if (!fifo_full) next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_done) next_state = ST_PUSH;
         end
         ST_PUSH: begin
            fifo_push  = 1'b1;
            frame_done = lat_last;
            if (lat_last)
               next_state = (single_frame || !enable) ? ST_IDLE : ST_APPLY;
            else
               next_state = (enable && room_after_push) ? ST_ISSUE : ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Registered run pulse and capture of the finished pixel result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_run     <= 1'b0;
         seen_running <= 1'b0;
         lat_nibble   <= '0;
         lat_last     <= 1'b0;
      end else begin
         core_run <= (state == ST_ISSUE);
         if (state == ST_ISSUE)
            seen_running <= 1'b0;
         else if ((state == ST_WAIT) && core_running)
            seen_running <= 1'b1;
         if (wait_done) begin
            lat_nibble <= core_ctr_out;
            lat_last   <= core_finished;
         end
      end
   end

   // Config shadow: host writes pending, APPLY moves pending into active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_cfg   <= CFG_RESET;
         active_cfg    <= CFG_RESET;
         pending_valid <= 1'b0;
         apply_done    <= 1'b0;
      end else begin
         apply_done <= (state == ST_APPLY);
         if (cfg_copy) begin
            active_cfg    <= pending_cfg;
            pending_valid <= 1'b0;
         end
         if (cfg_accept) begin
            pending_cfg   <= incoming_cfg;
            pending_valid <= 1'b1;
         end
      end
   end

   // Frame counter advances on entry to the last pixel's PUSH cycle so the
   // new value is visible alongside frame_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        frame_count <= '0;
      else if (wait_done && core_finished) frame_count <= frame_count + 1'b1;
   end

   mandelbrot_pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NIBBLE_W + 1)
   ) u_pixel_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({lat_last, lat_nibble}),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandelbrot_frame_ctrl
// Description : Directed self-checking bench for mandelbrot_frame_ctrl with a
//               behavioural 4x2-pixel core (5-cycle compute, result equals
//               pixel index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandelbrot_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, single_frame;
   logic        cfg_valid, cfg_ready;
   logic [6:0]  cfg_max_ctr;
   logic [2:0]  cfg_ctr_select;
   logic [6:0]  cfg_scaling;
   logic [9:0]  cfg_cr_offset, cfg_ci_offset;
   logic        core_run, core_running, core_finished;
   logic [3:0]  core_ctr_out;
   logic [6:0]  core_max_ctr;
   logic [2:0]  core_ctr_select;
   logic [6:0]  core_scaling;
   logic [9:0]  core_cr_offset, core_ci_offset;
   logic        pix_valid, pix_ready, pix_last, frame_done, busy;
   logic [3:0]  pix_data;
   logic [15:0] frame_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mandelbrot_frame_ctrl #(
      .FIFO_DEPTH (4),
      .BITWIDTH   (10),
      .CTRWIDTH   (7)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .single_frame    (single_frame),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_max_ctr     (cfg_max_ctr),
      .cfg_ctr_select  (cfg_ctr_select),
      .cfg_scaling     (cfg_scaling),
      .cfg_cr_offset   (cfg_cr_offset),
      .cfg_ci_offset   (cfg_ci_offset),
      .core_run        (core_run),
      .core_running    (core_running),
      .core_finished   (core_finished),
      .core_ctr_out    (core_ctr_out),
      .core_max_ctr    (core_max_ctr),
      .core_ctr_select (core_ctr_select),
      .core_scaling    (core_scaling),
      .core_cr_offset  (core_cr_offset),
      .core_ci_offset  (core_ci_offset),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_data        (pix_data),
      .pix_last        (pix_last),
      .frame_done      (frame_done),
      .frame_count     (frame_count),
      .busy            (busy)
   );

   // Behavioural core: 8 pixels per frame, 5-cycle compute, result = index
   int model_idx;
   int model_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_running  <= 1'b0;
         core_finished <= 1'b1;
         core_ctr_out  <= 4'd0;
         model_idx     <= 0;
         model_cnt     <= 0;
      end else if (core_run && !core_running) begin
         core_running  <= 1'b1;
         core_finished <= 1'b0;
         model_cnt     <= 5;
      end else if (core_running) begin
         if (model_cnt == 1) begin
            core_running  <= 1'b0;
            core_ctr_out  <= model_idx[3:0];
            core_finished <= (model_idx == 7);
            model_idx     <= (model_idx + 1) % 8;
         end
         model_cnt <= model_cnt - 1;
      end
   end

   // Observers: popped pixels, run pulses and frame_done pulses
   logic [4:0] seen_q[$];
   int   run_cnt   = 0;
   int   run_long  = 0;
   int   fd_pulses = 0;
   int   fd_long   = 0;
   logic run_prev  = 1'b0;
   logic fd_prev   = 1'b0;
   always @(posedge clk) begin
      if (pix_valid && pix_ready) seen_q.push_back({pix_last, pix_data});
      if (core_run) run_cnt <= run_cnt + 1;
      if (core_run && run_prev) run_long <= run_long + 1;
      if (frame_done) fd_pulses <= fd_pulses + 1;
      if (frame_done && fd_prev) fd_long <= fd_long + 1;
      run_prev <= core_run;
      fd_prev  <= frame_done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] get_pix(input int idx);
      if (idx < seen_q.size()) return seen_q[idx];
      return 5'bxxxxx;
   endfunction

   task automatic check_frame(input string tag, input int base);
      logic [4:0] p;
      for (int i = 0; i < 8; i++) begin
         p = get_pix(base + i);
         check($sformatf("%s_data%0d", tag, i), {28'd0, p[3:0]}, i);
         check($sformatf("%s_last%0d", tag, i), {31'd0, p[4]}, (i == 7) ? 1 : 0);
      end
   endtask

   task automatic wait_frame_done(input int lim);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (frame_done !== 1'b1 && k < lim);
      check("frame_done_seen", {31'd0, frame_done}, 1);
   endtask

   task automatic wait_runs(input int target, input int lim);
      int k = 0;
      while (run_cnt < target && k < lim) begin
         @(negedge clk);
         k++;
      end
      check("runs_reached", (run_cnt >= target) ? 1 : 0, 1);
   endtask

   task automatic send_cfg(input logic [6:0] mc, input logic [2:0] sel,
                           input logic [6:0] sc, input logic [9:0] cr,
                           input logic [9:0] ci);
      cfg_max_ctr    = mc;
      cfg_ctr_select = sel;
      cfg_scaling    = sc;
      cfg_cr_offset  = cr;
      cfg_ci_offset  = ci;
      cfg_valid      = 1'b1;
      @(negedge clk);
      cfg_valid      = 1'b0;
   endtask

   int base_r, base_q, base_fd;

   initial begin
      rst_n = 1'b0; enable = 1'b0; single_frame = 1'b1; pix_ready = 1'b1;
      cfg_valid = 1'b0; cfg_max_ctr = '0; cfg_ctr_select = '0; cfg_scaling = '0;
      cfg_cr_offset = '0; cfg_ci_offset = '0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_core_run",   {31'd0, core_run}, 0);
      check("rst_pix_valid",  {31'd0, pix_valid}, 0);
      check("rst_pix_data",   {28'd0, pix_data}, 0);
      check("rst_frame_done", {31'd0, frame_done}, 0);
      check("rst_busy",       {31'd0, busy}, 0);
      check("rst_cfg_ready",  {31'd0, cfg_ready}, 1);
      check("rst_frame_cnt",  {16'd0, frame_count}, 0);
      check("rst_max_ctr",    {25'd0, core_max_ctr}, 32'h7F);
      check("rst_scaling",    {25'd0, core_scaling}, 0);
      check("rst_cr_offset",  {22'd0, core_cr_offset}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame, pixels in order
      base_r = run_cnt; base_q = seen_q.size(); base_fd = fd_pulses;
      enable = 1'b1;
      wait_frame_done(400);
      enable = 1'b0;
      check("fc_with_done", {16'd0, frame_count}, 1);
      repeat (6) @(negedge clk);
      check("f1_runs", run_cnt - base_r, 8);
      check("f1_pixels", seen_q.size() - base_q, 8);
      check_frame("f1", base_q);
      check("f1_done_pulses", fd_pulses - base_fd, 1);
      check("f1_busy_idle", {31'd0, busy}, 0);

      // Back-pressure with a 4-entry FIFO
      base_r = run_cnt; base_q = seen_q.size();
      pix_ready = 1'b0; enable = 1'b1;
      repeat (200) @(negedge clk);
      check("bp_runs_stall", run_cnt - base_r, 4);
      check("bp_no_pop", seen_q.size() - base_q, 0);
      check("bp_head_valid", {31'd0, pix_valid}, 1);
      check("bp_head_data", {28'd0, pix_data}, 0);
      pix_ready = 1'b1;
      wait_frame_done(600);
      enable = 1'b0;
      repeat (6) @(negedge clk);
      check("bp_runs_total", run_cnt - base_r, 8);
      check("bp_pixels", seen_q.size() - base_q, 8);
      check_frame("bp", base_q);
      check("bp_frame_cnt", {16'd0, frame_count}, 2);

      // Config shadowing across back-to-back frames
      base_r = run_cnt; base_fd = fd_pulses;
      single_frame = 1'b0; enable = 1'b1;
      wait_runs(base_r + 3, 200);
      send_cfg(7'h20, 3'd3, 7'd9, 10'h155, 10'h0AA);
      check("cs_ready_low", {31'd0, cfg_ready}, 0);
      check("cs_scaling_held", {25'd0, core_scaling}, 0);
      wait_frame_done(400);
      check("cs_scaling_at_done", {25'd0, core_scaling}, 0);
      check("cs_frame_cnt", {16'd0, frame_count}, 3);
      repeat (2) @(negedge clk);
      check("cs_scaling_new", {25'd0, core_scaling}, 9);
      check("cs_max_ctr_new", {25'd0, core_max_ctr}, 32'h20);
      check("cs_select_new", {29'd0, core_ctr_select}, 3);
      check("cs_cr_new", {22'd0, core_cr_offset}, 32'h155);
      check("cs_ci_new", {22'd0, core_ci_offset}, 32'h0AA);
      check("cs_ready_high", {31'd0, cfg_ready}, 1);
      wait_frame_done(400);
      wait_frame_done(400);
      single_frame = 1'b1; enable = 1'b0;
      check("cont_frame_cnt", {16'd0, frame_count}, 5);
      repeat (6) @(negedge clk);
      check("cont_done_pulses", fd_pulses - base_fd, 3);
      check("cont_done_width", fd_long, 0);
      check("cont_busy_idle", {31'd0, busy}, 0);

      // Pause during pixel 3, resume without an APPLY
      base_r = run_cnt; base_q = seen_q.size();
      enable = 1'b1;
      wait_runs(base_r + 4, 200);
      enable = 1'b0;
      repeat (40) @(negedge clk);
      check("pause_runs", run_cnt - base_r, 4);
      check("pause_pixels", seen_q.size() - base_q, 4);
      check("pause_pix3", {27'd0, get_pix(base_q + 3)}, 32'h03);
      check("pause_busy", {31'd0, busy}, 0);
      send_cfg(7'h11, 3'd1, 7'd5, 10'h001, 10'h002);
      check("pause_cfg_pending", {31'd0, cfg_ready}, 0);
      pix_ready = 1'b0;
      enable = 1'b1;
      wait_runs(base_r + 6, 200);
      check("resume_no_apply", {25'd0, core_scaling}, 9);
      check("resume_pix_valid", {31'd0, pix_valid}, 1);
      check("resume_pix4_data", {28'd0, pix_data}, 4);
      check("resume_pix4_last", {31'd0, pix_last}, 0);

      // Reset while the core is computing pixel 5
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("mr_core_run",   {31'd0, core_run}, 0);
      check("mr_pix_valid",  {31'd0, pix_valid}, 0);
      check("mr_pix_data",   {28'd0, pix_data}, 0);
      check("mr_pix_last",   {31'd0, pix_last}, 0);
      check("mr_frame_done", {31'd0, frame_done}, 0);
      check("mr_busy",       {31'd0, busy}, 0);
      check("mr_cfg_ready",  {31'd0, cfg_ready}, 1);
      check("mr_frame_cnt",  {16'd0, frame_count}, 0);
      check("mr_scaling",    {25'd0, core_scaling}, 0);
      check("mr_max_ctr",    {25'd0, core_max_ctr}, 32'h7F);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_empty", {31'd0, pix_valid}, 0);
      check("post_rst_busy",  {31'd0, busy}, 0);
      check("run_pulse_width", run_long, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
